// File: rtl/dsp38_fir_sequencer.sv
// Time-multiplexed FIR tap sequencer for one DSP38 MAC: one tap per cycle, then a wait
// for the DSP pipeline before capturing Z.
module dsp38_fir_sequencer #(
    parameter int          NUM_TAPS    = 4,
    parameter logic [19:0] COEFF_0     = 20'h00000,
    parameter logic [19:0] COEFF_1     = 20'h00000,
    parameter logic [19:0] COEFF_2     = 20'h00000,
    parameter logic [19:0] COEFF_3     = 20'h00000,
    parameter int          ZIN_LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [17:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        UNSIGNED_IN,
    input  logic        FLUSH,
    output logic [19:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [2:0]  DSP_FEEDBACK,
    output logic        DSP_LOAD_ACC,
    output logic        DSP_UNSIGNED_A,
    output logic        DSP_UNSIGNED_B,
    input  logic [37:0] DSP_Z,
    output logic [37:0] DOUT,
    output logic        DOUT_VALID,
    output logic        BUSY
);

    if (NUM_TAPS < 1 || NUM_TAPS > 4 || ZIN_LATENCY < 1 || ZIN_LATENCY > 7) begin : g_bad_param
        $fatal(1, "dsp38_fir_sequencer: NUM_TAPS must be 1..4 and ZIN_LATENCY 1..7");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0]       LAST_TAP  = 2'(NUM_TAPS - 1);
    localparam logic [2:0]       LAST_WAIT = 3'(ZIN_LATENCY - 1);
    localparam logic [3:0][19:0] COEFFS    = {COEFF_3, COEFF_2, COEFF_1, COEFF_0};

    logic [1:0]       state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [3:0][17:0] x_q, x_d;
    logic             uns_q, uns_d;
    logic [19:0]      dsp_a_q, dsp_a_d;
    logic [17:0]      dsp_b_q, dsp_b_d;
    logic [2:0]       dsp_fb_q, dsp_fb_d;
    logic             dsp_ld_q, dsp_ld_d;
    logic [37:0]      dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        wcnt_d       = wcnt_q;
        x_d          = x_q;
        uns_d        = uns_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (FLUSH) begin
                    x_d = '0;
                end else if (IN_VALID) begin
                    // Taps at or beyond NUM_TAPS are never written and stay zero.
                    for (int i = 1; i < 4; i++) begin
                        if (i < NUM_TAPS) x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = IN_DATA;
                    uns_d   = UNSIGNED_IN;
                    state_d = ST_MAC;
                    k_d     = 2'd0;
                end
            end
            ST_MAC: begin
                if (k_q == LAST_TAP) begin
                    state_d = ST_WAIT;
                    k_d     = 2'd0;
                    wcnt_d  = 3'd0;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == LAST_WAIT) begin
                    state_d      = ST_IDLE;
                    wcnt_d       = 3'd0;
                    dout_d       = DSP_Z;
                    dout_valid_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // DSP ports are registered from the next state so they line up with the MAC cycles.
    always_comb begin
        dsp_a_d  = '0;
        dsp_b_d  = '0;
        dsp_fb_d = '0;
        dsp_ld_d = 1'b0;
        if (state_d == ST_MAC) begin
            dsp_a_d  = COEFFS[k_d];
            dsp_b_d  = x_d[k_d];
            dsp_ld_d = 1'b1;
            dsp_fb_d = (k_d == 2'd0) ? 3'b001 : 3'b000;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            wcnt_q       <= '0;
            x_q          <= '0;
            uns_q        <= 1'b0;
            dsp_a_q      <= '0;
            dsp_b_q      <= '0;
            dsp_fb_q     <= '0;
            dsp_ld_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wcnt_q       <= wcnt_d;
            x_q          <= x_d;
            uns_q        <= uns_d;
            dsp_a_q      <= dsp_a_d;
            dsp_b_q      <= dsp_b_d;
            dsp_fb_q     <= dsp_fb_d;
            dsp_ld_q     <= dsp_ld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign IN_READY       = RESET_N && (state_q == ST_IDLE) && !FLUSH;
    assign BUSY           = (state_q != ST_IDLE);
    assign DSP_A          = dsp_a_q;
    assign DSP_B          = dsp_b_q;
    assign DSP_FEEDBACK   = dsp_fb_q;
    assign DSP_LOAD_ACC   = dsp_ld_q;
    assign DSP_UNSIGNED_A = 1'b0;
    assign DSP_UNSIGNED_B = uns_q;
    assign DOUT           = dout_q;
    assign DOUT_VALID     = dout_valid_q;

endmodule

// File: doc/dsp38_fir_sequencer.md
DSP38_FIR_SEQUENCER -- requirements
Module: dsp38_fir_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, number of FIR taps issued per sample (legal 1..4).
REQ-002 SHALL have parameters COEFF_0..COEFF_3, each [19:0], default 20'h00000, signed tap coefficients; tap k uses COEFF_k.
REQ-003 SHALL have parameter ZIN_LATENCY, default 3, number of cycles from the last issued tap to DSP_Z validity (legal 1..7).
REQ-004 SHALL have a single clock: CLK  input  1  clock; all state updates occur on the rising edge.
REQ-005 SHALL have RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have IN_DATA  input  18  input sample.
REQ-007 SHALL have IN_VALID  input  1  sample valid.
REQ-008 SHALL have IN_READY  output  1  sample accepted when IN_VALID and IN_READY are both high at a rising edge.
REQ-009 SHALL have UNSIGNED_IN  input  1  sample is unsigned; captured on accept.
REQ-010 SHALL have FLUSH  input  1  synchronous clear of the delay line.
REQ-011 SHALL have DSP_A  output  20, DSP_B  output  18, DSP_FEEDBACK  output  3, DSP_LOAD_ACC  output  1, DSP_UNSIGNED_A  output  1 and DSP_UNSIGNED_B  output  1; these drive the DSP38 ports of the same name minus the DSP_ prefix.
REQ-012 SHALL have DSP_Z  input  38  DSP38 Z result.
REQ-013 SHALL have DOUT  output  38 (filter result), DOUT_VALID  output  1 (one-cycle strobe) and BUSY  output  1 (state not IDLE).

Function
REQ-014 SHALL target DSP38 configured with DSP_MODE=MULTIPLY_ACCUMULATE, INPUT_REG_EN=TRUE and OUTPUT_REG_EN=TRUE; with that configuration ZIN_LATENCY=3.
REQ-015 SHALL implement FSM states IDLE -> MAC -> WAIT -> IDLE.
REQ-016 IN_READY SHALL be high only in IDLE with FLUSH low; no output backpressure exists.
REQ-017 On accept, the delay line SHALL shift x[i] <= x[i-1] for i = 1..NUM_TAPS-1 and load x[0] <= IN_DATA; UNSIGNED_IN SHALL be latched; the FSM SHALL enter MAC with tap counter k=0.
REQ-018 FLUSH high in IDLE SHALL clear x[] to 0, take precedence over IN_VALID, and result in no accept; FLUSH SHALL be ignored outside IDLE.
REQ-019 MAC SHALL last exactly NUM_TAPS cycles, one per tap k: DSP_A=COEFF_k, DSP_B=x[k], DSP_LOAD_ACC=1, DSP_FEEDBACK=3'b001 for k=0 and 3'b000 for k>0.
REQ-020 Outside MAC, DSP_A, DSP_B, DSP_LOAD_ACC and DSP_FEEDBACK SHALL all be 0.
REQ-021 DSP_UNSIGNED_A SHALL be constant 0 (signed coefficients); DSP_UNSIGNED_B SHALL equal the latched UNSIGNED_IN and hold until the next accept.
REQ-022 All DSP_* outputs SHALL be registered.
REQ-023 WAIT SHALL last ZIN_LATENCY cycles; DSP_Z SHALL be sampled at the edge ending the last WAIT cycle into DOUT; DOUT_VALID SHALL be high for exactly the following cycle, which is the first IDLE cycle.
REQ-024 Latency from the accept edge to DOUT_VALID SHALL be 1+NUM_TAPS+ZIN_LATENCY cycles; the default is 8.
REQ-025 Throughput SHALL be one sample per 1+NUM_TAPS+ZIN_LATENCY cycles.
REQ-026 A new accept in the DOUT_VALID cycle SHALL be legal.
REQ-027 DOUT SHALL hold its value until the next capture.
REQ-028 NUM_TAPS outside 1..4 or ZIN_LATENCY outside 1..7 SHALL cause $fatal at time 0.
REQ-029 Arithmetic SHALL be performed by DSP38; the sequencer SHALL pass DSP_Z through unmodified (no truncation or sign handling).

Reset
REQ-030 RESET_N low SHALL immediately force: state IDLE, k=0, wait counter 0, x[] all 0, latched unsigned flag 0, all DSP_* outputs 0, DOUT 0, DOUT_VALID 0, BUSY 0.
REQ-031 IN_READY SHALL be 0 while RESET_N is low and 1 from the first cycle after release (FLUSH low).
REQ-032 Reset asserted during MAC or WAIT SHALL abort the operation, with no DOUT_VALID for the in-flight sample.

Verification (bench: sequencer driving a DSP38 as in REQ-014, DSP Z looped to DSP_Z)
REQ-033 COEFF_0..3 = 1,2,3,4; samples 1,0,0,0 (signed) -> DOUT strobes 1,2,3,4, each strobe 8 cycles after its accept.
REQ-034 COEFF_0=5, others 0; IN_DATA=18'h3FFFF with UNSIGNED_IN=0 -> DOUT=38'h3FFFFFFFFB; same sample with UNSIGNED_IN=1 -> DOUT=38'h000013FFFB.
REQ-035 IN_VALID held high with incrementing data -> accepts exactly every 8 cycles; during MAC, DSP_FEEDBACK = 001,000,000,000, DSP_LOAD_ACC = 1,1,1,1 and DSP_A = COEFF_0..3.
REQ-036 RESET_N pulsed low in the 2nd MAC cycle -> all outputs 0 and no DOUT_VALID; then impulse 1,0,0,0 -> DOUT 1,2,3,4 with no residue from before the reset.
REQ-037 History loaded with 7s, then FLUSH and IN_VALID high in the same IDLE cycle -> no accept that cycle; the next sample 1 yields DOUT=1 (zero history).
REQ-038 NUM_TAPS=1, ZIN_LATENCY=3, COEFF_0=20'hFFFFF (-1), sample 3 -> DOUT=38'h3FFFFFFFFD, 5 cycles after accept.
